// File: rtl/filter_pkg.sv
// Shared definitions for the filter bank: pixel width, 3x3 window slot layout,
// scheduler state encoding and the window packing helper.
package filter_pkg;
  localparam int PIX_W = 12;
  localparam int WIN_W = 9 * PIX_W;

  localparam int SLOT_C  = 96;
  localparam int SLOT_L  = 84;
  localparam int SLOT_R  = 72;
  localparam int SLOT_U  = 60;
  localparam int SLOT_D  = 48;
  localparam int SLOT_UL = 36;
  localparam int SLOT_UR = 24;
  localparam int SLOT_DL = 12;
  localparam int SLOT_DR = 0;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_t;

  function automatic logic [WIN_W-1:0] pack_window(
    input logic [PIX_W-1:0] c, l, r, u, d, ul, ur, dl, dr);
    logic [WIN_W-1:0] w;
    w = '0;
    w[SLOT_C  +: PIX_W] = c;
    w[SLOT_L  +: PIX_W] = l;
    w[SLOT_R  +: PIX_W] = r;
    w[SLOT_U  +: PIX_W] = u;
    w[SLOT_D  +: PIX_W] = d;
    w[SLOT_UL +: PIX_W] = ul;
    w[SLOT_UR +: PIX_W] = ur;
    w[SLOT_DL +: PIX_W] = dl;
    w[SLOT_DR +: PIX_W] = dr;
    return w;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: combinational read and registered write at the same
// address, so a read in the write cycle returns the previous line's pixel.
module line_buffer #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 12,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/filter_window_scheduler.sv
// Raster RGB444 stream to 3x3 windows (one per pixel) with prime/stream/flush
// sequencing. Define FILTER_BORDER_REPLICATE_EN to clamp borders instead of zero-fill.
module filter_window_scheduler
  import filter_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sof,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIN_W-1:0] win_data,
  output logic             win_valid,
  input  logic             win_ready,
  output logic             win_last,
  output logic             busy
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H + 2);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef logic [2:0][2:0][PIX_W-1:0] win3_t;  // [row][col], row 0 = top, col 0 = left

  state_t state, state_nxt;
  logic [XW-1:0] ix, cx, lb_addr;
  logic [YW-1:0] iy, cy;
  win3_t win_q, win_nxt;
  logic [PIX_W-1:0] lb0_rd, lb1_rd, pix_col;
  logic out_free, acc, restart, emit, advance;

  assign busy     = (state != IDLE);
  assign out_free = !win_valid || win_ready;
  assign pix_ready = reset && (state != FLUSH) && out_free;
  assign acc      = pix_valid && pix_ready;
  assign restart  = acc && sof;
  // FLUSH pushes zero "virtual" pixels through the same shift path.
  assign emit     = (state == STREAM && acc && !sof) ||
                    (state == FLUSH && out_free && !(win_valid && win_last));
  assign advance  = restart || emit || (state == PRIME && acc);
  assign lb_addr  = restart ? '0 : ix;
  assign pix_col  = (state == FLUSH) ? '0 : pix_in;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_lb0 (
    .clk(clk), .we(advance), .addr(lb_addr), .wdata(pix_col), .rdata(lb0_rd));
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_lb1 (
    .clk(clk), .we(advance), .addr(lb_addr), .wdata(lb0_rd), .rdata(lb1_rd));

  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win_q[r][1];
      win_nxt[r][1] = win_q[r][2];
    end
    win_nxt[0][2] = lb1_rd;
    win_nxt[1][2] = lb0_rd;
    win_nxt[2][2] = pix_col;
  end

  // Edge columns of the shift window hold wrapped pixels; they are never used as-is.
  function automatic logic [PIX_W-1:0] nb(input win3_t w, input logic [1:0] r,
                                          input logic [1:0] c, input logic [XW-1:0] x,
                                          input logic [YW-1:0] y);
    logic out_x, out_y;
    out_x = (c == 2'd0 && x == '0) || (c == 2'd2 && x == X_LAST);
    out_y = (r == 2'd0 && y == '0) || (r == 2'd2 && y == Y_LAST);
`ifdef FILTER_BORDER_REPLICATE_EN
    return w[out_y ? 2'd1 : r][out_x ? 2'd1 : c];
`else
    return (out_x || out_y) ? '0 : w[r][c];
`endif
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (restart) state_nxt = PRIME;
      PRIME:   if (!restart && acc && ix == '0 && iy == YW'(1)) state_nxt = STREAM;
      STREAM:  if (restart) state_nxt = PRIME;
               else if (acc && ix == X_LAST && iy == Y_LAST) state_nxt = FLUSH;
      FLUSH:   if (win_valid && win_ready && win_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ix        <= '0;
      iy        <= '0;
      cx        <= '0;
      cy        <= '0;
      win_q     <= '0;
      win_data  <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        win_q <= win_nxt;
        if (restart) begin
          ix <= XW'(1);
          iy <= '0;
        end else if (ix == X_LAST) begin
          ix <= '0;
          iy <= iy + 1'b1;
        end else begin
          ix <= ix + 1'b1;
        end
      end
      if (restart) begin
        cx        <= '0;
        cy        <= '0;
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end else if (emit) begin
        win_data  <= pack_window(nb(win_nxt, 2'd1, 2'd1, cx, cy), nb(win_nxt, 2'd1, 2'd0, cx, cy),
                                 nb(win_nxt, 2'd1, 2'd2, cx, cy), nb(win_nxt, 2'd0, 2'd1, cx, cy),
                                 nb(win_nxt, 2'd2, 2'd1, cx, cy), nb(win_nxt, 2'd0, 2'd0, cx, cy),
                                 nb(win_nxt, 2'd0, 2'd2, cx, cy), nb(win_nxt, 2'd2, 2'd0, cx, cy),
                                 nb(win_nxt, 2'd2, 2'd2, cx, cy));
        win_valid <= 1'b1;
        win_last  <= (cx == X_LAST) && (cy == Y_LAST);
        if (cx == X_LAST) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_filter_window_scheduler.sv
// Randomized bench for filter_window_scheduler (4x3 frame) against a frame-array
// reference model; honours FILTER_BORDER_REPLICATE_EN for border values.
module tb_filter_window_scheduler;
  localparam int W = 4, H = 3, N = W * H;

  logic clk = 0, reset = 0, sof = 0, pix_valid = 0, win_ready = 0;
  logic [11:0] pix_in = '0;
  logic pix_ready, win_valid, win_last, busy;
  logic [107:0] win_data;

  int checks = 0, failures = 0;
  int mode = 1, gaps = 0;
  logic [108:0] exp_q[$];
  logic [108:0] obs[$];
  logic [11:0] frm[N];
  longint first_vld_t = -1, last_acc_t = 0, acc5_t = 0;
  logic stall_q = 0;
  logic [108:0] stall_v = '0;

  filter_window_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .sof(sof), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_data(win_data), .win_valid(win_valid),
    .win_ready(win_ready), .win_last(win_last), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] px(input int x, input int y);
    int xx = x, yy = y;
`ifdef FILTER_BORDER_REPLICATE_EN
    xx = (x < 0) ? 0 : (x >= W) ? W - 1 : x;
    yy = (y < 0) ? 0 : (y >= H) ? H - 1 : y;
`else
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
`endif
    return frm[yy * W + xx];
  endfunction

  function automatic logic [107:0] win_at(input int n);
    int x = n % W, y = n / W;
    return {px(x, y), px(x-1, y), px(x+1, y), px(x, y-1), px(x, y+1),
            px(x-1, y-1), px(x+1, y-1), px(x-1, y+1), px(x+1, y+1)};
  endfunction

  task automatic expect_wins(input int cnt, input logic full);
    for (int n = 0; n < cnt; n++) exp_q.push_back({full && (n == N - 1), win_at(n)});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    case (mode)
      0:       win_ready = 1'b0;
      1:       win_ready = 1'b1;
      2:       win_ready = ~win_ready;
      default: win_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send(input logic [11:0] p, input logic s, output logic ok);
    int t = 0;
    ok = 1'b0;
    if (gaps != 0)
      while ($urandom_range(0, 3) == 0) begin pix_valid = 1'b0; next_cycle(); end
    pix_valid = 1'b1; pix_in = p; sof = s;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (pix_ready) begin ok = 1'b1; last_acc_t = $time; end
      next_cycle();
      t++;
    end
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic drive_frame(input int npix);
    logic ok;
    for (int i = 0; i < npix; i++) begin
      send(frm[i], i == 0, ok);
      if (!ok) chk("pix_timeout", ok, 1'b1);
      if (i == W + 1) acc5_t = last_acc_t;
    end
    if (npix == N) begin
      @(negedge clk);
      chk("flush_busy_rdy", {busy, pix_ready}, 2'b10);
      next_cycle();
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin next_cycle(); t++; end
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    next_cycle();
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
  endtask

  // Output monitor: scoreboard pops on each transfer and checks hold during stalls.
  always @(negedge clk) begin
    if (!reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) chk("hold", {win_valid, win_last, win_data}, {1'b1, stall_v});
      if (win_valid && !win_ready) chk("stall_pix_ready", pix_ready, 1'b0);
      if (win_valid && first_vld_t < 0) first_vld_t = $time;
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) chk("extra_win", win_valid, 1'b0);
        else begin
          chk("win", {win_last, win_data}, exp_q.pop_front());
          obs.push_back({win_last, win_data});
        end
      end
      stall_q = win_valid && !win_ready;
      stall_v = {win_last, win_data};
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {win_valid, win_last, busy, pix_ready}, 4'b0000);
    chk("rst_data", win_data, 108'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed 1..12 frame, always ready, no gaps: latency and border values.
    for (int i = 0; i < N; i++) frm[i] = 12'(i + 1);
    mode = 1; gaps = 0; obs.delete(); first_vld_t = -1;
    expect_wins(N, 1'b1);
    drive_frame(N);
    drain();
    chk("t1_latency", 128'(first_vld_t - acc5_t), 128'd10);
    chk("t1_count", obs.size(), N);
    if (obs.size() == N) begin
`ifdef FILTER_BORDER_REPLICATE_EN
      chk("t1_n0", obs[0], {1'b0, 108'h001_001_002_001_005_001_002_005_006});
      chk("t3_wrap_n3", obs[3], {1'b0, 108'h004_003_004_004_008_003_004_007_008});
      chk("t1_n11", obs[11], {1'b1, 108'h00C_00B_00C_008_00C_007_008_00B_00C});
`else
      chk("t1_n0", obs[0], {1'b0, 108'h001_000_002_000_005_000_000_000_006});
      chk("t3_wrap_n3", obs[3], {1'b0, 108'h004_003_000_000_008_000_000_007_000});
      chk("t1_n11", obs[11], {1'b1, 108'h00C_00B_000_008_000_007_000_000_000});
`endif
    end

    // Same frame, toggling win_ready with input gaps.
    mode = 2; gaps = 1;
    expect_wins(N, 1'b1);
    drive_frame(N);
    drain();

    // Abort at pixel 7: first frame emits n=0,1 only, then a full new frame.
    mode = 3;
    rand_frame();
    expect_wins(7 - W - 1, 1'b0);
    drive_frame(7);
    rand_frame();
    expect_wins(N, 1'b1);
    drive_frame(N);
    drain();

    // Pixels without sof in IDLE are dropped.
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1; sof = 1'b0; pix_in = 12'($urandom);
      @(negedge clk);
      chk("idle_drop", {pix_ready, win_valid, busy}, 3'b100);
      next_cycle();
    end
    pix_valid = 1'b0;

    // Reset during FLUSH, then a clean frame.
    rand_frame();
    expect_wins(N, 1'b1);
    drive_frame(N);
    mode = 0;
    next_cycle(); next_cycle();
    reset = 1'b0;
    #1;
    chk("flush_rst", {win_valid, busy, pix_ready}, 3'b000);
    exp_q.delete();
    @(negedge clk);
    chk("flush_rst_hold", {win_valid, busy}, 2'b00);
    mode = 3;
    next_cycle();
    reset = 1'b1;
    rand_frame();
    expect_wins(N, 1'b1);
    drive_frame(N);
    drain();

    // A few more random frames with random back-pressure.
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      expect_wins(N, 1'b1);
      drive_frame(N);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
